// File: rtl/retire_stage_if.sv
// retire_stage_if
//   Bundles the ROB-to-retire packet bus with the free-list return strobes.
//   The ROB side uses the master modport; retire_stage uses the slave
//   modport.
//
//   rob_retire_valid  slot i holds a packet popped from the ROB this cycle
//   rob_packet_in     head and head+1 ROB packets
//   free_valid        registered T_old return strobes to the free list
//   free_preg         registered T_old tags
//
//   PREG_IDX_WIDTH falls back to 6 bits when the core does not define it.

`ifndef PREG_IDX_WIDTH
`define PREG_IDX_WIDTH 6
`endif

interface retire_stage_if #(
  parameter int PREG_W = `PREG_IDX_WIDTH
);

  typedef struct packed {
    logic [31:0]       PC;
    logic [31:0]       NPC;
    logic [PREG_W-1:0] T_new;
    logic [PREG_W-1:0] T_old;
    logic [31:0]       inst;
    logic              halt;
    logic              illegal;
  } rob_packet_t;

  logic [1:0]              rob_retire_valid;
  rob_packet_t [1:0]       rob_packet_in;
  logic [1:0]              free_valid;
  logic [1:0][PREG_W-1:0]  free_preg;

  modport master (
    output rob_retire_valid,
    output rob_packet_in,
    input  free_valid,
    input  free_preg
  );

  modport slave (
    input  rob_retire_valid,
    input  rob_packet_in,
    output free_valid,
    output free_preg
  );

endinterface

// File: rtl/retire_stage.sv
// retire_stage
//   Two-wide in-order commit stage. It retires up to two ROB packets per
//   cycle, updates the architectural map (ARAT), returns superseded physical
//   tags to the free list and sequences halt / illegal-instruction shutdown.
//
//   clock       core clock
//   reset       asynchronous, active-low reset
//   rob_if      slave side of retire_stage_if (ROB packets in, frees out)
//   arat_map    current architectural map, used by flush recovery
//   flush       one-cycle pulse while draining after a halt/illegal commit
//   halted      core stopped by a halt instruction
//   error       core stopped by an illegal instruction
//   retire_cnt  instructions committed in the previous cycle (0-2)
//
//   Optional feature macro RETIRE_PERF_EN adds perf_retired and perf_cycles,
//   two saturating 64-bit counters.

`ifndef PREG_IDX_WIDTH
`define PREG_IDX_WIDTH 6
`endif

module retire_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PREG_W    = `PREG_IDX_WIDTH
) (
  input  logic                             clock,
  input  logic                             reset,
  retire_stage_if.slave                    rob_if,
  output logic [ARCH_REGS-1:0][PREG_W-1:0] arat_map,
  output logic                             flush,
  output logic                             halted,
  output logic                             error,
  output logic [1:0]                       retire_cnt
`ifdef RETIRE_PERF_EN
  ,
  output logic [63:0]                      perf_retired,
  output logic [63:0]                      perf_cycles
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED, ERROR} state_e;

  state_e                            state_q, state_d;
  logic [ARCH_REGS-1:0][PREG_W-1:0]  arat_q, arat_d;
  logic [1:0]                        free_valid_q, free_valid_d;
  logic [1:0][PREG_W-1:0]            free_preg_q, free_preg_d;
  logic [1:0]                        retire_cnt_q, retire_cnt_d;
  logic                              kind_illegal_q;

  logic [1:0][4:0]                   rd;
  logic [1:0]                        has_dest;
  logic [1:0]                        stops;
  logic [1:0]                        commit;
  logic                              trigger;
  logic                              trig_illegal;

  // PC, NPC and the non-rd instruction bits travel with the packet but are
  // not needed to commit it.
  logic unused_bits;
  assign unused_bits = ^{rob_if.rob_packet_in[0].PC, rob_if.rob_packet_in[0].NPC,
                         rob_if.rob_packet_in[1].PC, rob_if.rob_packet_in[1].NPC,
                         rob_if.rob_packet_in[0].inst[31:12], rob_if.rob_packet_in[0].inst[6:0],
                         rob_if.rob_packet_in[1].inst[31:12], rob_if.rob_packet_in[1].inst[6:0]};

  // Per-slot decode: a destination needs a nonzero T_new and a nonzero rd.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rd[i]       = rob_if.rob_packet_in[i].inst[11:7];
      has_dest[i] = (rob_if.rob_packet_in[i].T_new != '0) && (rd[i] != 5'd0);
      stops[i]    = rob_if.rob_packet_in[i].halt | rob_if.rob_packet_in[i].illegal;
    end
  end

  // Commit datapath. Slot 1 is applied after slot 0 so it wins an rd
  // collision, and a stopping slot 0 discards slot 1 entirely.
  always_comb begin
    arat_d       = arat_q;
    free_valid_d = '0;
    free_preg_d  = '0;
    retire_cnt_d = '0;
    commit       = '0;
    trigger      = 1'b0;
    trig_illegal = 1'b0;
    if (state_q == RUN) begin
      commit[0] = rob_if.rob_retire_valid[0];
      commit[1] = rob_if.rob_retire_valid[1] & ~(commit[0] & stops[0]);
      for (int i = 0; i < 2; i++) begin
        if (commit[i]) begin
          if (has_dest[i]) begin
            arat_d[rd[i]]   = rob_if.rob_packet_in[i].T_new;
            free_valid_d[i] = 1'b1;
            free_preg_d[i]  = rob_if.rob_packet_in[i].T_old;
          end
          if (stops[i] && !trigger) begin
            trigger      = 1'b1;
            trig_illegal = rob_if.rob_packet_in[i].illegal;
          end
        end
      end
      retire_cnt_d = 2'(commit[0]) + 2'(commit[1]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        arat_q[i] <= PREG_W'(i);
      end
      free_valid_q   <= '0;
      free_preg_q    <= '0;
      retire_cnt_q   <= '0;
      kind_illegal_q <= 1'b0;
    end else begin
      arat_q       <= arat_d;
      free_valid_q <= free_valid_d;
      free_preg_q  <= free_preg_d;
      retire_cnt_q <= retire_cnt_d;
      if (trigger) begin
        kind_illegal_q <= trig_illegal;
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. DRAIN lasts exactly one cycle; HALTED/ERROR absorb.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (trigger) state_d = DRAIN;
      DRAIN:   state_d = kind_illegal_q ? ERROR : HALTED;
      default: state_d = state_q;
    endcase
  end

  // FSM: outputs. flush is simply "in DRAIN", so it is one cycle wide and
  // drops asynchronously with reset.
  always_comb begin
    flush  = (state_q == DRAIN);
    halted = (state_q == HALTED);
    error  = (state_q == ERROR);
  end

  assign arat_map          = arat_q;
  assign rob_if.free_valid = free_valid_q;
  assign rob_if.free_preg  = free_preg_q;
  assign retire_cnt        = retire_cnt_q;

`ifdef RETIRE_PERF_EN
  logic [63:0] perf_retired_q, perf_cycles_q;
  logic [64:0] retired_sum;

  // Widen by one bit so a carry out means the counter must saturate.
  assign retired_sum = {1'b0, perf_retired_q} + 65'(retire_cnt_d);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_retired_q <= '0;
      perf_cycles_q  <= '0;
    end else begin
      perf_retired_q <= retired_sum[64] ? '1 : retired_sum[63:0];
      if ((state_q == RUN || state_q == DRAIN) && perf_cycles_q != '1) begin
        perf_cycles_q <= perf_cycles_q + 64'd1;
      end
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_cycles  = perf_cycles_q;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// tb_retire_stage
//   Scoreboard bench for retire_stage. Stimulus pushes the expected commit
//   response into a queue; a monitor pops it whenever the DUT shows a
//   retire count, a free strobe or a flush. The reference model walks the
//   two slots in order and stops at the first halt/illegal packet.

module tb_retire_stage;

  localparam int PW = 6;

  logic                clock = 1'b0;
  logic                reset;
  logic [31:0][PW-1:0] arat_map;
  logic                flush;
  logic                halted;
  logic                error;
  logic [1:0]          retire_cnt;
`ifdef RETIRE_PERF_EN
  logic [63:0]         perf_retired;
  logic [63:0]         perf_cycles;
`endif

  retire_stage_if #(.PREG_W(PW)) rif ();

  retire_stage #(.ARCH_REGS(32), .PREG_W(PW)) dut (
    .clock        (clock),
    .reset        (reset),
    .rob_if       (rif),
    .arat_map     (arat_map),
    .flush        (flush),
    .halted       (halted),
    .error        (error),
    .retire_cnt   (retire_cnt)
`ifdef RETIRE_PERF_EN
    ,
    .perf_retired (perf_retired),
    .perf_cycles  (perf_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]    rd;
    logic [PW-1:0] tNew;
    logic [PW-1:0] tOld;
    logic          halt;
    logic          illegal;
  } tbPkt;

  typedef struct {
    logic [1:0]          cnt;
    logic [1:0]          freeValid;
    logic [1:0][PW-1:0]  freePreg;
    logic                flush;
    logic [31:0][PW-1:0] arat;
  } expEntry;

  expEntry             expQ[$];
  logic [31:0][PW-1:0] modelArat;
  bit                  modelStopped;
  bit                  modelIllegal;
  int                  checkCount = 0;
  int                  passCount  = 0;
  tbPkt                zeroPkt = '{rd: 5'd0, tNew: '0, tOld: '0, halt: 1'b0, illegal: 1'b0};

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 32; i++) modelArat[i] = PW'(i);
    modelStopped = 1'b0;
    modelIllegal = 1'b0;
  endfunction

  // Reference model: retire slots in order, stop after the first packet
  // carrying halt or illegal, and record what the next cycle must show.
  function automatic void modelStep(input logic [1:0] v, input tbPkt p0, input tbPkt p1);
    tbPkt    p[2];
    expEntry e;
    p[0] = p0;
    p[1] = p1;
    e.cnt       = '0;
    e.freeValid = '0;
    e.freePreg  = '0;
    e.flush     = 1'b0;
    if (modelStopped) return;
    for (int i = 0; i < 2; i++) begin
      if (!v[i]) break;
      e.cnt = e.cnt + 2'd1;
      if (p[i].tNew != '0 && p[i].rd != 5'd0) begin
        modelArat[p[i].rd] = p[i].tNew;
        e.freeValid[i] = 1'b1;
        e.freePreg[i]  = p[i].tOld;
      end
      if (p[i].halt || p[i].illegal) begin
        modelStopped = 1'b1;
        modelIllegal = p[i].illegal;
        e.flush      = 1'b1;
        break;
      end
    end
    e.arat = modelArat;
    if (e.cnt != 2'd0) expQ.push_back(e);
  endfunction

  function automatic tbPkt mk(input int rd, input int tn, input int to,
                              input logic h, input logic il);
    tbPkt p;
    p.rd      = 5'(rd);
    p.tNew    = PW'(tn);
    p.tOld    = PW'(to);
    p.halt    = h;
    p.illegal = il;
    return p;
  endfunction

  function automatic tbPkt randPkt();
    tbPkt p;
    p.rd      = 5'($urandom_range(0, 7));
    p.tNew    = ($urandom_range(0, 4) == 0) ? '0 : PW'($urandom_range(1, 63));
    p.tOld    = PW'($urandom_range(0, 63));
    p.halt    = ($urandom_range(0, 59) == 0);
    p.illegal = ($urandom_range(0, 59) == 0);
    return p;
  endfunction

  task automatic drivePkt(input int slot, input tbPkt p);
    rif.rob_packet_in[slot].PC         = $urandom;
    rif.rob_packet_in[slot].NPC        = $urandom;
    rif.rob_packet_in[slot].inst       = $urandom;
    rif.rob_packet_in[slot].inst[11:7] = p.rd;
    rif.rob_packet_in[slot].T_new      = p.tNew;
    rif.rob_packet_in[slot].T_old      = p.tOld;
    rif.rob_packet_in[slot].halt       = p.halt;
    rif.rob_packet_in[slot].illegal    = p.illegal;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input tbPkt p0, input tbPkt p1);
    @(negedge clock);
    rif.rob_retire_valid = v;
    drivePkt(0, p0);
    drivePkt(1, p1);
    modelStep(v, p0, p1);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(2'b00, zeroPkt, zeroPkt);
  endtask

  // Level checks for quiet cycles, where the monitor has nothing to pop.
  task automatic checkState(input string tag);
    checkOutput({tag, ".arat"}, 256'(arat_map), 256'(modelArat));
    checkOutput({tag, ".halted"}, 256'(halted), 256'(modelStopped && !modelIllegal));
    checkOutput({tag, ".error"}, 256'(error), 256'(modelStopped && modelIllegal));
    checkOutput({tag, ".flush"}, 256'(flush), 256'(0));
    checkOutput({tag, ".retireCnt"}, 256'(retire_cnt), 256'(0));
    checkOutput({tag, ".freeValid"}, 256'(rif.free_valid), 256'(0));
  endtask

  task automatic doReset();
    checkOutput("queueDrained", 256'(expQ.size()), 256'(0));
    expQ.delete();
    @(negedge clock);
    reset = 1'b0;
    rif.rob_retire_valid = 2'b00;
    modelReset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Monitor: pop one expectation whenever the DUT presents a response.
  initial begin
    expEntry e;
    forever begin
      @(posedge clock);
      #1;
      if (reset && (rif.free_valid != 2'b00 || retire_cnt != 2'd0 || flush)) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOutput", {retire_cnt, rif.free_valid, flush}, 256'(0));
        end else begin
          e = expQ.pop_front();
          checkOutput("retireCnt", 256'(retire_cnt), 256'(e.cnt));
          checkOutput("freeValid", 256'(rif.free_valid), 256'(e.freeValid));
          checkOutput("freePreg0", 256'(e.freeValid[0] ? rif.free_preg[0] : '0), 256'(e.freePreg[0]));
          checkOutput("freePreg1", 256'(e.freeValid[1] ? rif.free_preg[1] : '0), 256'(e.freePreg[1]));
          checkOutput("flush", 256'(flush), 256'(e.flush));
          checkOutput("haltErrEarly", 256'({halted, error}), 256'(0));
          checkOutput("aratMap", 256'(arat_map), 256'(e.arat));
        end
      end
    end
  end

  initial begin
    logic [1:0] v;
    reset = 1'b0;
    rif.rob_retire_valid = 2'b00;
    rif.rob_packet_in    = '0;
    modelReset();
    repeat (3) @(negedge clock);
    reset = 1'b1;

    idle(5);
    checkState("reset");

    applyStimulus(2'b01, mk(5, 40, 5, 1'b0, 1'b0), zeroPkt);
    idle(2);
    checkState("slot0Only");

    applyStimulus(2'b11, mk(7, 41, 7, 1'b0, 1'b0), mk(7, 42, 41, 1'b0, 1'b0));
    idle(2);
    checkState("sameRd");

    applyStimulus(2'b11, mk(0, 12, 9, 1'b1, 1'b0), mk(3, 50, 3, 1'b0, 1'b0));
    idle(3);
    checkState("halt");
    repeat (6) applyStimulus(2'b11, mk(4, 33, 4, 1'b0, 1'b0), mk(6, 34, 6, 1'b0, 1'b0));
    idle(2);
    checkState("afterHalt");
    doReset();

    applyStimulus(2'b11, mk(9, 20, 9, 1'b0, 1'b0), mk(10, 21, 10, 1'b0, 1'b1));
    idle(3);
    checkState("illegalSlot1");
    doReset();

    applyStimulus(2'b01, mk(4, 22, 4, 1'b1, 1'b1), zeroPkt);
    idle(3);
    checkState("haltAndIllegal");
    doReset();

    // Reset landing in the middle of the drain cycle.
    applyStimulus(2'b01, mk(6, 30, 6, 1'b1, 1'b0), zeroPkt);
    @(posedge clock);
    #3;
    reset = 1'b0;
    rif.rob_retire_valid = 2'b00;
    #1;
    expQ.delete();
    modelReset();
    checkState("drainReset");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int ep = 0; ep < 8; ep++) begin
      for (int c = 0; c < 40; c++) begin
        case ($urandom_range(0, 3))
          0:       v = 2'b00;
          1:       v = 2'b01;
          default: v = 2'b11;
        endcase
        applyStimulus(v, randPkt(), randPkt());
      end
      idle(3);
      checkState("random");
      doReset();
    end

    idle(3);
    checkState("final");
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
